// File: rtl/isqrt_seq.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_seq
// Purpose  : Bit-exact sequential integer square root, one root bit per cycle,
//            with valid/ready handshakes on input and output.
// Revision : 1.0 - initial release
// ============================================================================
module isqrt_seq #(
    parameter  int IN_W  = 16,
    localparam int OUT_W = IN_W / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_root,
    output logic [OUT_W:0]   out_rem,
    output logic             busy
);

    localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_W - 1);

    generate
        if ((IN_W % 2) != 0 || IN_W < 4) begin : g_bad_in_w
            $error("isqrt_seq: IN_W must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IN_W-1:0]    op_q;
    logic [OUT_W-1:0]   root_q;
    logic [OUT_W+1:0]   rem_q;
    logic [OUT_W-1:0]   out_root_q;
    logic [OUT_W:0]     out_rem_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [OUT_W+1:0]   rem_sh;
    logic [OUT_W+1:0]   trial;
    logic               fits;
    logic [OUT_W+1:0]   rem_d;
    logic [OUT_W-1:0]   root_d;

    // One restoring step: bring down the next two operand bits and try 4*root+1.
    always_comb begin
        rem_sh = {rem_q[OUT_W-1:0], op_q[IN_W-1 -: 2]};
        trial  = {root_q, 2'b01};
        fits   = (rem_sh >= trial);
        rem_d  = fits ? (rem_sh - trial) : rem_sh;
        root_d = {root_q[OUT_W-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            out_root_q  <= '0;
            out_rem_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (ena) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_data;
                        root_q  <= '0;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    op_q   <= {op_q[IN_W-3:0], 2'b00};
                    root_q <= root_d;
                    rem_q  <= rem_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        // The final remainder never exceeds 2*root, so its top bit is always zero.
                        out_root_q  <= root_d;
                        out_rem_q   <= rem_d[OUT_W:0];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && ena && !rst;
    assign out_valid = out_valid_q;
    assign out_root  = out_root_q;
    assign out_rem   = out_rem_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire
